// File: rtl/cpu_run_ctrl_if.sv
// Debug/commit bus between the PDU, the CPU control path and the run sequencer.
interface cpu_run_ctrl_if #(
    parameter int unsigned BP_IDX_W = 2,
    parameter int unsigned CNT_W    = 32
);
    // PDU control
    logic                run;
    logic                step;
    logic                halt;
    logic                bp_we;
    logic [BP_IDX_W-1:0] bp_idx;
    logic [31:0]         bp_addr;
    logic                bp_en;
    logic                cnt_clr;
    // CPU side requests
    logic [31:0]         current_pc;
    logic                wb_en_req;
    logic                mem_we_req;
    // Sequencer results
    logic                cpu_en;
    logic                wb_en;
    logic                mem_we;
    logic [1:0]          state;
    logic [CNT_W-1:0]    retired;

    // Driving side (PDU + CPU control)
    modport master (
        output run, step, halt, bp_we, bp_idx, bp_addr, bp_en, cnt_clr,
        output current_pc, wb_en_req, mem_we_req,
        input  cpu_en, wb_en, mem_we, state, retired
    );

    // Sequencer side
    modport slave (
        input  run, step, halt, bp_we, bp_idx, bp_addr, bp_en, cnt_clr,
        input  current_pc, wb_en_req, mem_we_req,
        output cpu_en, wb_en, mem_we, state, retired
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Execution sequencer: halt/run/step control, PC breakpoints, commit gating
// and retired-instruction counting for the single-cycle CPU.
module cpu_run_ctrl #(
    parameter int unsigned BP_IDX_W = 2,
    parameter int unsigned CNT_W    = 32
) (
    input  logic            clk,
    input  logic            rst,
    cpu_run_ctrl_if.slave   bus
);
    localparam int unsigned NBRK = 1 << BP_IDX_W;

    typedef enum logic [1:0] {
        ST_HALT = 2'd0,
        ST_RUN  = 2'd1,
        ST_STEP = 2'd2,
        ST_BRK  = 2'd3
    } state_e;

    state_e           state_q;
    state_e           state_n;
    logic             skip_q;
    logic             skip_n;
    logic [31:0]      bp_pc_q [NBRK];
    logic [NBRK-1:0]  bp_en_q;
    logic             bp_match;
    logic             bp_hit;
    logic             cpu_en;
    logic [CNT_W-1:0] retired_q;

    // Any enabled breakpoint slot matching the presented PC
    always_comb begin
        bp_match = 1'b0;
        for (int unsigned i = 0; i < NBRK; i++) begin
            if (bp_en_q[i] && (bp_pc_q[i] == bus.current_pc)) begin
                bp_match = 1'b1;
            end
        end
    end

    // Next-state, breakpoint hit and commit enable
    always_comb begin
        state_n = state_q;
        bp_hit  = 1'b0;
        cpu_en  = 1'b0;
        unique case (state_q)
            ST_HALT: begin
                if (bus.run) begin
                    state_n = ST_RUN;
                end else if (bus.step) begin
                    state_n = ST_STEP;
                end
            end
            ST_RUN: begin
                bp_hit = !skip_q && bp_match;
                cpu_en = !bp_hit;
                if (bus.halt) begin
                    state_n = ST_HALT;
                end else if (bp_hit) begin
                    state_n = ST_BRK;
                end
            end
            ST_STEP: begin
                cpu_en  = 1'b1;
                state_n = ST_HALT;
            end
            ST_BRK: begin
                if (bus.halt) begin
                    state_n = ST_HALT;
                end else if (bus.run) begin
                    state_n = ST_RUN;
                end else if (bus.step) begin
                    state_n = ST_STEP;
                end
            end
            default: state_n = ST_HALT;
        endcase
        // First RUN cycle after any entry into RUN ignores breakpoints
        skip_n = (state_q != ST_RUN) && (state_n == ST_RUN);
    end

    // State and skip-flag registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_HALT;
            skip_q  <= 1'b0;
        end else begin
            state_q <= state_n;
            skip_q  <= skip_n;
        end
    end

    // Breakpoint slot registers, writable in any state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < NBRK; i++) begin
                bp_pc_q[i] <= '0;
            end
            bp_en_q <= '0;
        end else if (bus.bp_we) begin
            bp_pc_q[bus.bp_idx] <= bus.bp_addr;
            bp_en_q[bus.bp_idx] <= bus.bp_en;
        end
    end

    // Retired-instruction counter; clear wins over a coincident commit
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            retired_q <= '0;
        end else if (bus.cnt_clr) begin
            retired_q <= '0;
        end else if (cpu_en) begin
            retired_q <= retired_q + CNT_W'(1);
        end
    end

    assign bus.cpu_en  = cpu_en;
    assign bus.wb_en   = bus.wb_en_req & cpu_en;
    assign bus.mem_we  = bus.mem_we_req & cpu_en;
    assign bus.state   = state_q;
    assign bus.retired = retired_q;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl: steps, breakpoints, skip, halt latency,
// counter wrap/clear and asynchronous reset.
module tb_cpu_run_ctrl;
    localparam int unsigned BP_IDX_W = 2;
    localparam int unsigned CNT_W    = 4;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_fail;
    int   n_commits;

    cpu_run_ctrl_if #(.BP_IDX_W(BP_IDX_W), .CNT_W(CNT_W)) bus ();

    cpu_run_ctrl #(.BP_IDX_W(BP_IDX_W), .CNT_W(CNT_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against its expected value
    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // One clock; the modelled CPU advances its PC by 4 on each commit
    task automatic tick();
        logic en;
        @(negedge clk);
        en = bus.cpu_en;
        @(posedge clk);
        #1;
        if (en) begin
            bus.current_pc = bus.current_pc + 32'd4;
            n_commits++;
        end
        #1;
    endtask

    task automatic pulse_run();
        bus.run = 1'b1; tick(); bus.run = 1'b0;
    endtask

    task automatic pulse_step();
        bus.step = 1'b1; tick(); bus.step = 1'b0;
    endtask

    task automatic pulse_halt();
        bus.halt = 1'b1; tick(); bus.halt = 1'b0;
    endtask

    task automatic write_bp(input int idx, input logic [31:0] addr, input logic en);
        bus.bp_we   = 1'b1;
        bus.bp_idx  = BP_IDX_W'(idx);
        bus.bp_addr = addr;
        bus.bp_en   = en;
        tick();
        bus.bp_we   = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_fail = 0;
        n_commits = 0;
        rst = 1'b0;
        bus.run = 1'b0; bus.step = 1'b0; bus.halt = 1'b0;
        bus.bp_we = 1'b0; bus.bp_idx = '0; bus.bp_addr = '0; bus.bp_en = 1'b0;
        bus.cnt_clr = 1'b0;
        bus.current_pc = 32'h3000;
        bus.wb_en_req = 1'b1;
        bus.mem_we_req = 1'b1;

        // Reset values
        tick(); tick();
        check("rst_state", 32'(bus.state), 32'd0);
        check("rst_cpu_en", 32'(bus.cpu_en), 32'd0);
        check("rst_mem_we", 32'(bus.mem_we), 32'd0);
        rst = 1'b1;
        tick();
        check("rst_retired", 32'(bus.retired), 32'd0);
        check("idle_cpu_en", 32'(bus.cpu_en), 32'd0);

        // Three single steps, four cycles apart
        n_commits = 0;
        for (int k = 0; k < 3; k++) begin
            pulse_step();
            check("step_state", 32'(bus.state), 32'd2);
            check("step_cpu_en", 32'(bus.cpu_en), 32'd1);
            tick();
            check("step_back_halt", 32'(bus.state), 32'd0);
            check("step_en_off", 32'(bus.cpu_en), 32'd0);
            tick(); tick(); tick();
        end
        check("step_commits", 32'(n_commits), 32'd3);
        check("step_retired", 32'(bus.retired), 32'd3);
        check("step_pc", bus.current_pc, 32'h300C);

        // Breakpoint in slot 1; disabled slot 2 must never hit
        write_bp(1, 32'h3010, 1'b1);
        write_bp(2, 32'h3004, 1'b0);
        bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
        check("clr_retired", 32'(bus.retired), 32'd0);
        bus.current_pc = 32'h3000;
        #1;
        pulse_run();
        check("run_state", 32'(bus.state), 32'd1);
        check("run_cpu_en", 32'(bus.cpu_en), 32'd1);
        check("run_mem_we", 32'(bus.mem_we), 32'd1);
        tick(); tick(); tick(); tick();
        check("bp_pc", bus.current_pc, 32'h3010);
        check("bp_cpu_en", 32'(bus.cpu_en), 32'd0);
        check("bp_mem_we", 32'(bus.mem_we), 32'd0);
        check("bp_wb_en", 32'(bus.wb_en), 32'd0);
        check("bp_state_same_cycle", 32'(bus.state), 32'd1);
        tick();
        check("brk_state", 32'(bus.state), 32'd3);
        check("brk_retired", 32'(bus.retired), 32'd4);
        check("brk_pc_held", bus.current_pc, 32'h3010);

        // Resume from BRK: the breakpoint instruction commits via skip
        pulse_run();
        check("resume_state", 32'(bus.state), 32'd1);
        check("resume_cpu_en", 32'(bus.cpu_en), 32'd1);
        tick(); tick();
        check("resume_pc", bus.current_pc, 32'h3018);
        check("resume_retired", 32'(bus.retired), 32'd6);
        pulse_halt();
        check("halt_state", 32'(bus.state), 32'd0);
        check("halt_retired", 32'(bus.retired), 32'd7);
        check("halt_pc", bus.current_pc, 32'h301C);

        // run+step together, then halt coinciding with a breakpoint match
        bus.run = 1'b1; bus.step = 1'b1; tick(); bus.run = 1'b0; bus.step = 1'b0;
        check("run_step_prio", 32'(bus.state), 32'd1);
        write_bp(0, 32'h3024, 1'b1);
        tick();
        check("halt_bp_pc", bus.current_pc, 32'h3024);
        check("halt_bp_cpu_en", 32'(bus.cpu_en), 32'd0);
        pulse_halt();
        check("halt_bp_state", 32'(bus.state), 32'd0);
        check("halt_bp_retired", 32'(bus.retired), 32'd9);

        // Preload counter to 15 by running, then one step wraps it
        pulse_run();
        tick(); tick(); tick(); tick(); tick();
        pulse_halt();
        check("pre_wrap_retired", 32'(bus.retired), 32'd15);
        pulse_step();
        tick();
        check("wrap_retired", 32'(bus.retired), 32'd0);

        // Clear coinciding with a commit yields zero
        pulse_step();
        tick();
        check("one_step_retired", 32'(bus.retired), 32'd1);
        pulse_step();
        bus.cnt_clr = 1'b1; tick(); bus.cnt_clr = 1'b0;
        check("clr_vs_commit", 32'(bus.retired), 32'd0);

        // step held two edges: second sample in STEP is ignored
        bus.step = 1'b1; tick(); tick(); bus.step = 1'b0;
        check("step_held_state", 32'(bus.state), 32'd0);
        check("step_held_retired", 32'(bus.retired), 32'd1);

        // Asynchronous reset mid-RUN
        bus.current_pc = 32'h3008;
        #1;
        pulse_run();
        check("pre_rst_cpu_en", 32'(bus.cpu_en), 32'd1);
        rst = 1'b0;
        #1;
        check("arst_cpu_en", 32'(bus.cpu_en), 32'd0);
        check("arst_wb_en", 32'(bus.wb_en), 32'd0);
        check("arst_state", 32'(bus.state), 32'd0);
        check("arst_retired", 32'(bus.retired), 32'd0);
        tick();
        rst = 1'b1;
        bus.current_pc = 32'h3008;
        #1;
        pulse_run();
        tick();
        tick();
        check("post_rst_pc", bus.current_pc, 32'h3010);
        check("post_rst_no_bp", 32'(bus.cpu_en), 32'd1);
        tick();
        check("post_rst_state", 32'(bus.state), 32'd1);
        check("post_rst_retired", 32'(bus.retired), 32'd3);
        pulse_halt();
        check("post_rst_halt", 32'(bus.state), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/cpu_run_ctrl.md
# cpu_run_ctrl

Execution sequencer for the single-cycle RISC-V CPU.
- Decides each cycle whether the CPU commits an instruction: it gates the PC register update, register-file write and data-memory write through one clock-enable.
- Provides halt / run / single-step control and hardware PC breakpoints, driven from the PDU debug bus.
- Counts retired instructions.
- Sits between the PDU and the CPU top; the CPU's own `wb_en` and `mem_we` pass through it.

## Interface

Parameters
- `BP_IDX_W`, default 2: breakpoint index width. Breakpoint count `NBRK = 2**BP_IDX_W`.
- `CNT_W`, default 32: width of the retired-instruction counter.

Ports
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `run`  in  1  one-cycle pulse: enter continuous run.
- `step`  in  1  one-cycle pulse: execute exactly one instruction.
- `halt`  in  1  one-cycle pulse: stop.
- `bp_we`  in  1  breakpoint register write strobe.
- `bp_idx`  in  BP_IDX_W  breakpoint slot to write.
- `bp_addr`  in  32  breakpoint PC value.
- `bp_en`  in  1  enable bit written with `bp_addr`.
- `cnt_clr`  in  1  synchronous clear of the retired counter.
- `current_pc`  in  32  PC of the instruction currently presented by the CPU.
- `wb_en_req`  in  1  register-file write request from CPU control.
- `mem_we_req`  in  1  data-memory write request from CPU control.
- `cpu_en`  out  1  commit enable for the CPU (PC register load).
- `wb_en`  out  1  gated register-file write enable.
- `mem_we`  out  1  gated data-memory write enable.
- `state`  out  2  encoding: 0=HALT, 1=RUN, 2=STEP, 3=BRK.
- `retired`  out  CNT_W  retired-instruction count.

## Operation

Gating and commit
- `cpu_en = (state==RUN && !bp_hit) || state==STEP`.
- `wb_en = wb_en_req & cpu_en`; `mem_we = mem_we_req & cpu_en`. Both are combinational.
- When `cpu_en`=0, the CPU must hold its PC, and no architectural write occurs.

Breakpoint hit
- `bp_hit` is asserted when all of these hold: `state==RUN`, `skip`=0, and some slot i has `bp_en[i]`=1 and `bp_pc[i]==current_pc`.
- Any slot matching causes a hit.
- The instruction at the breakpoint PC is not executed.

`skip` flag
- Set on every entry into RUN.
- Cleared after the first RUN cycle.
- Effect: the first instruction after a run resumes even if its PC matches a breakpoint.

State transitions, evaluated at each edge:
- HALT:
  - `run` → RUN. `run` takes priority if `run` and `step` are both asserted.
  - `step` alone → STEP.
  - Otherwise stay in HALT.
- RUN:
  - `halt` → HALT. `halt` takes priority over `bp_hit`.
  - `bp_hit` → BRK.
  - Otherwise stay in RUN. `run` and `step` are ignored.
- STEP: unconditionally → HALT. All inputs are ignored, and breakpoints are not checked.
- BRK:
  - `run` → RUN, with `skip` set.
  - `step` → STEP.
  - `halt` → HALT.
  - Priority: `halt` > `run` > `step`.

Breakpoint registers
- `bp_we` writes `bp_pc[bp_idx] <= bp_addr` and `bp_en[bp_idx] <= bp_en` at the edge.
- The written value is used for comparison from the next cycle on.
- Writes are allowed in any state.

Retired counter
- Increments by 1 on each edge where `cpu_en`=1.
- Wraps modulo 2^CNT_W.
- `cnt_clr` takes priority: if it coincides with an increment, the result is 0.

## Timing

Reset (`rst`=0)
- Takes effect immediately, asynchronously, including mid-RUN or mid-STEP.
- Values: `state`=HALT, `skip`=0, `retired`=0, all `bp_en`=0, all `bp_pc`=0.
- Outputs `cpu_en`, `wb_en` and `mem_we` are 0 while in reset.

Latency
- A control pulse at edge k takes effect in the cycle after edge k: `cpu_en` becomes 1 in that cycle for `run` or `step`.
- The cycle in which `halt` is sampled during RUN still commits. Exactly one further instruction retires after `halt` is asserted.
- STEP produces exactly one cycle with `cpu_en`=1.
- A breakpoint hit is detected in the same cycle as the matching `current_pc`. `cpu_en` is 0 in that cycle, and `state` reads BRK from the next cycle.

Boundary conditions
- A pulse held longer than one cycle is re-sampled each edge.
- A second `step` while in STEP is ignored.

Combinational paths
- `current_pc` → `bp_hit` → `cpu_en` / `wb_en` / `mem_we`.
- There is no combinational path from `run`, `step`, `halt` or `bp_*` to any output.

## Test plan

- Reset, then `step` ×3 pulses spaced 4 cycles apart → exactly three 1-cycle `cpu_en` pulses, `retired`=3, `state` back to 0 after each.
- Slot 1 = 0x0000_3010 enabled; `run` with PC advancing 0x3000, 0x3004, ... → `cpu_en`=0 when `current_pc`=0x3010, `state`=3, `retired`=4, `mem_we`=0 even with `mem_we_req`=1.
- From that BRK, `run` → the instruction at 0x3010 commits (`skip`), then RUN continues. `halt` in a later cycle → that cycle commits, then `state`=0.
- `run` and `step` in the same cycle from HALT → `state`=1. `halt` coinciding with a breakpoint match in RUN → `state`=0, no commit.
- `retired` preloaded to 2^CNT_W−1 by running, then one step → 0. `cnt_clr` coinciding with a commit → `retired`=0.
- Assert `rst` low mid-RUN → outputs 0 immediately. After release, breakpoints are disabled and `run` executes straight past 0x3010.
